cache_burst_responder: RTL and testbench

//  Memory-side responder for the two-way cache's 16-bit fill/write channel.

---
 rtl/cache_burst_responder.sv | 151 +++++++++++++++
 tb/tb_cache_burst_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_burst_responder.sv
// rtl/cache_burst_responder.sv - cache line fill / single-word write responder on a word-wide memory port
module cache_burst_responder #(
  parameter int ADDR_W = 28
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       cache_addr_i,
  input  logic              sdram_req_i,
  input  logic              sdram_rw_i,
  input  logic [15:0]       data_to_sdram_i,
  output logic [15:0]       data_from_sdram_o,
  output logic              sdram_fill_o,
  output logic              sdram_wrack_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    STREAM = 3'd2,
    WRLO   = 3'd3,
    WRMEM  = 3'd4,
    WRDONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  // FETCH: word index k (bits [1:0]); STREAM: halfword index j (bits [2:0])
  logic [2:0]        cnt_q, cnt_d;
  // latched word address; bits [1:0] hold the critical word for reads
  logic [ADDR_W-3:0] waddr_q, waddr_d;
  // cleared by the fill strobe, set again once the cache has dropped its request
  logic              armed_q, armed_d;
  // the write acknowledge has already been pulsed in this WRDONE visit
  logic              acked_q, acked_d;
  // line buffer in fetch order (critical word first); word 0 doubles as write buffer
  logic [31:0]       line_q [4];
  logic [1:0]        word_sel;
  logic              unused_addr;

  assign unused_addr = ^{cache_addr_i[31:ADDR_W], cache_addr_i[1:0]};
  // wrapping 2-bit add keeps the fetch inside the aligned line
  assign word_sel    = waddr_q[1:0] + cnt_q[1:0];

  // State and control registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      waddr_q <= '0;
      armed_q <= 1'b1;
      acked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      armed_q <= armed_d;
      acked_q <= acked_d;
    end
  end

  // Line buffer capture; reset only blocks writes and never clears the contents
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == IDLE && sdram_req_i && armed_q && !sdram_rw_i) begin
        line_q[0][31:16] <= data_to_sdram_i;
      end
      if (state_q == WRLO) begin
        line_q[0][15:0] <= data_to_sdram_i;
      end
      if (state_q == FETCH && mem_ack_i) begin
        line_q[cnt_q[1:0]] <= mem_rdata_i;
      end
    end
  end

  // Next-state and output decode; every output idles at zero
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    waddr_d           = waddr_q;
    armed_d           = armed_q | ~sdram_req_i;
    acked_d           = acked_q;
    data_from_sdram_o = 16'h0000;
    sdram_fill_o      = 1'b0;
    sdram_wrack_o     = 1'b0;
    mem_addr_o        = '0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_wdata_o       = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        // mem_ack is deliberately ignored here so stale acks are dropped
        if (sdram_req_i && armed_q) begin
          waddr_d = cache_addr_i[ADDR_W-1:2];
          cnt_d   = 3'd0;
          acked_d = 1'b0;
          state_d = sdram_rw_i ? FETCH : WRLO;
        end
      end
      FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {waddr_q[ADDR_W-3:2], word_sel};
        if (mem_ack_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = 3'd0;
            armed_d = 1'b0;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        // the cache cannot stall, so the index advances every cycle
        data_from_sdram_o = cnt_q[0] ? line_q[cnt_q[2:1]][15:0] : line_q[cnt_q[2:1]][31:16];
        sdram_fill_o      = (cnt_q == 3'd0);
        cnt_d             = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      WRLO: begin
        state_d = WRMEM;
      end
      WRMEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = waddr_q;
        mem_wdata_o = line_q[0];
        if (mem_ack_i) begin
          state_d = WRDONE;
        end
      end
      WRDONE: begin
        sdram_wrack_o = ~acked_q;
        acked_d       = 1'b1;
        if (!sdram_req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_burst_responder.sv
// tb/tb_cache_burst_responder.sv - self-checking bench for cache_burst_responder
module tb_cache_burst_responder;
  localparam int ADDR_W = 28;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       cache_addr = 32'h0;
  logic              sdram_req = 1'b0;
  logic              sdram_rw = 1'b0;
  logic [15:0]       data_to_sdram = 16'h0;
  logic [15:0]       data_from_sdram;
  logic              sdram_fill;
  logic              sdram_wrack;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  int          n_assert = 0;
  int          n_fail = 0;
  int          lat_cfg = 0;
  logic [31:0] mem_seed = 32'h0;
  logic        force_ack = 1'b0;

  // monitor-owned records
  logic [25:0] rd_q[$];
  logic [57:0] wr_q[$];
  logic [15:0] stream_q[$];
  int fill_cnt = 0, wrack_cnt = 0, stab_cnt = 0, cyc = 0, fill_cyc = 0, ack_cyc = 0;

  always #5 clk = ~clk;

  cache_burst_responder #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset), .cache_addr_i(cache_addr), .sdram_req_i(sdram_req),
    .sdram_rw_i(sdram_rw), .data_to_sdram_i(data_to_sdram), .data_from_sdram_o(data_from_sdram),
    .sdram_fill_o(sdram_fill), .sdram_wrack_o(sdram_wrack), .mem_addr_o(mem_addr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  function automatic logic [31:0] memword(input logic [25:0] a);
    return (32'hA0A1A2A3 + 32'(a) - 32'h48C) ^ mem_seed;
  endfunction

  // word i of the fetch order: same 16-byte line, critical word first, wrapping
  function automatic logic [25:0] model_addr(input logic [31:0] a, input int i);
    int unsigned ua, line, w;
    ua   = a % 32'h1000_0000;
    line = ua / 16;
    w    = ((ua / 4) + i) % 4;
    return 26'(line * 4 + w);
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " cache outs"}, 80'({data_from_sdram, sdram_fill, sdram_wrack}), 80'h0);
    check({name, " mem ctrl"}, 80'({mem_addr, mem_req, mem_we}), 80'h0);
    check({name, " mem_wdata"}, 80'(mem_wdata), 80'h0);
  endtask

  // memory: ack after lat_cfg wait cycles per word
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = force_ack;
      mem_rdata = 32'h0;
      if (mem_req) begin
        if (wait_cnt >= lat_cfg) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (!mem_we) mem_rdata = memword(mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: capture fills, stream, writes, reads and request stability
  initial begin
    int cap_left;
    logic was_wait, w_we;
    logic [25:0] w_addr;
    cap_left = 0; was_wait = 1'b0; w_we = 1'b0; w_addr = '0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (sdram_fill) begin fill_cnt++; cap_left = 8; fill_cyc = cyc; end
      if (cap_left > 0) begin stream_q.push_back(data_from_sdram); cap_left--; end
      if (sdram_wrack) wrack_cnt++;
      if (mem_req && mem_ack) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        else begin rd_q.push_back(mem_addr); ack_cyc = cyc; end
      end
      if (mem_req && was_wait && (mem_addr !== w_addr || mem_we !== w_we)) stab_cnt++;
      was_wait = mem_req && !mem_ack;
      w_addr   = mem_addr;
      w_we     = mem_we;
    end
  end

  task automatic do_txn(input logic rw, input logic [31:0] addr, input logic [15:0] hi,
                        input logic [15:0] lo, input int lat, input logic flip, input int hold);
    int t, rb, wb, sb, f0, k0, s0;
    logic [31:0] w;
    logic [15:0] eh;
    lat_cfg = lat;
    rb = rd_q.size(); wb = wr_q.size(); sb = stream_q.size();
    f0 = fill_cnt; k0 = wrack_cnt; s0 = stab_cnt;
    @(negedge clk);
    cache_addr = addr; sdram_rw = rw; data_to_sdram = hi; sdram_req = 1'b1;
    @(negedge clk);
    data_to_sdram = lo;
    if (flip) sdram_rw = ~rw;
    t = 0;
    while (!(rw ? (fill_cnt > f0) : (wrack_cnt > k0)) && t < 200) begin
      @(negedge clk); t++;
    end
    check("txn completion timeout", 80'(t >= 200), 80'h0);
    repeat (hold) @(negedge clk);
    sdram_req = 1'b0;
    repeat (12) @(negedge clk);
    check("request stability", 80'(stab_cnt - s0), 80'h0);
    if (rw) begin
      check("fill strobes", 80'(fill_cnt - f0), 80'd1);
      check("read word count", 80'(rd_q.size() - rb), 80'd4);
      check("no write on read", 80'(wr_q.size() - wb), 80'd0);
      check("fill after 4th ack", 80'(fill_cyc > ack_cyc), 80'd1);
      if (rd_q.size() - rb >= 4)
        for (int i = 0; i < 4; i++) check($sformatf("fetch addr %0d", i), 80'(rd_q[rb+i]), 80'(model_addr(addr, i)));
      check("stream length", 80'(stream_q.size() - sb), 80'd8);
      if (stream_q.size() - sb >= 8)
        for (int j = 0; j < 8; j++) begin
          w  = memword(model_addr(addr, j / 2));
          eh = (j % 2 == 0) ? w[31:16] : w[15:0];
          check($sformatf("halfword %0d", j), 80'(stream_q[sb+j]), 80'(eh));
        end
    end else begin
      check("wrack pulses", 80'(wrack_cnt - k0), 80'd1);
      check("write count", 80'(wr_q.size() - wb), 80'd1);
      check("no read on write", 80'(rd_q.size() - rb), 80'd0);
      if (wr_q.size() - wb >= 1)
        check("write addr/data", 80'(wr_q[wb]),
              80'({26'((addr % 32'h1000_0000) / 4), hi, lo}));
    end
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [15:0] hi;
    logic [15:0] lo;
    int          lat;
    logic [25:0] exp_addr0;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, rb, f0, wb;
    vecs[0] = '{1'b1, 32'h0000_1238, 16'h0, 16'h0, 0, 26'h48E, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_1238, 16'h0, 16'h0, 3, 26'h48E, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0010, 16'hDEAD, 16'hBEEF, 0, 26'h4, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'hF000_003C, 16'h0, 16'h0, 1, 26'hF, 32'h0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 16'h1234, 16'h5678, 2, 26'h3FFFFFF, 32'h12345678};
    vecs[5] = '{1'b1, 32'h0FFF_FFF4, 16'h0, 16'h0, 0, 26'h3FFFFFD, 32'h0};

    // reset held 3 cycles, release, stale ack in IDLE
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_idle("in reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2 check_idle("after release");
    @(negedge clk) force_ack = 1'b1;
    @(negedge clk) force_ack = 1'b0;
    repeat (2) begin
      @(posedge clk); #2 check_idle("stale ack idle");
    end
    check("stale ack no read", 80'(rd_q.size()), 80'd0);

    // table-driven transactions
    for (int v = 0; v < 6; v++) begin
      rb = rd_q.size(); wb = wr_q.size();
      mem_seed = 32'h0;
      do_txn(vecs[v].rw, vecs[v].addr, vecs[v].hi, vecs[v].lo, vecs[v].lat, 1'b0, 0);
      if (vecs[v].rw) begin
        if (rd_q.size() > rb) check($sformatf("vec %0d first addr", v), 80'(rd_q[rb]), 80'(vecs[v].exp_addr0));
      end else if (wr_q.size() > wb) begin
        check($sformatf("vec %0d wr addr", v), 80'(wr_q[wb][57:32]), 80'(vecs[v].exp_addr0));
        check($sformatf("vec %0d wr data", v), 80'(wr_q[wb][31:0]), 80'(vecs[v].exp_wdata));
      end
    end

    // reset in FETCH after the 2nd ack
    mem_seed = 32'h0; lat_cfg = 3;
    rb = rd_q.size(); f0 = fill_cnt;
    @(negedge clk);
    cache_addr = 32'h0000_2000; sdram_rw = 1'b1; sdram_req = 1'b1;
    t = 0;
    while (rd_q.size() - rb < 2 && t < 100) begin @(negedge clk); t++; end
    check("mid-fetch wait timeout", 80'(t >= 100), 80'h0);
    @(negedge clk);
    reset = 1'b1; sdram_req = 1'b0;
    @(posedge clk); #2 check("reset mid-fetch mem_req", 80'(mem_req), 80'h0);
    @(negedge clk) reset = 1'b0;
    repeat (15) @(negedge clk);
    check("no fill after abort", 80'(fill_cnt - f0), 80'h0);
    check("abort read count", 80'(rd_q.size() - rb), 80'd2);
    do_txn(1'b1, 32'h0000_2004, 16'h0, 16'h0, 0, 1'b0, 0);

    // request held high through STREAM and beyond, then low for one cycle
    lat_cfg = 0;
    rb = rd_q.size(); f0 = fill_cnt;
    @(negedge clk);
    cache_addr = 32'h0000_5554; sdram_rw = 1'b1; sdram_req = 1'b1;
    t = 0;
    while (fill_cnt == f0 && t < 100) begin @(negedge clk); t++; end
    check("held req fill timeout", 80'(t >= 100), 80'h0);
    repeat (9) @(negedge clk);
    check("held req no refetch", 80'(rd_q.size() - rb), 80'd4);
    check("held req one fill", 80'(fill_cnt - f0), 80'd1);
    sdram_req = 1'b0;
    @(negedge clk) sdram_req = 1'b1;
    t = 0;
    while (fill_cnt - f0 < 2 && t < 100) begin @(negedge clk); t++; end
    check("re-armed fill timeout", 80'(t >= 100), 80'h0);
    check("re-armed refetch", 80'(rd_q.size() - rb), 80'd8);
    sdram_req = 1'b0;
    repeat (12) @(negedge clk);

    // randomized transactions against the model
    for (int r = 0; r < 24; r++) begin
      mem_seed = $urandom;
      do_txn(1'($urandom_range(0, 1)), $urandom, 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
